// File: rtl/i2c_bit_controller.sv
// I2C bit-level sequencer: runs START/STOP/WRITE/READ as four equal phases,
// drives open-drain enables, honours clock stretching and flags arbitration loss.
module i2c_bit_controller #(
  parameter logic [7:0] DIV_SM  = 8'd124,
  parameter logic [7:0] DIV_FM  = 8'd31,
  parameter logic [7:0] DIV_FMP = 8'd12,
  parameter logic [7:0] DIV_HS  = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] freq_mode,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_code,
  input  logic       cmd_wdata,
  output logic       cmd_ready,
  output logic       busy,
  output logic       rsp_valid,
  output logic       rsp_rdata,
  output logic       arb_lost,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  typedef enum logic [1:0] {IDLE, START, STOP, BIT} state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  state_t     state, state_n;
  logic [1:0] ph, ph_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] div, div_n;
  logic [1:0] code, code_n;
  logic       wdata, wdata_n;
  logic       scl_oe_n, sda_oe_n;
  logic       busy_n, cmd_ready_n;
  logic       rsp_valid_n, rsp_rdata_n, arb_lost_n;
  logic       stretch, arb;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ph        <= 2'd0;
      cnt       <= 8'd0;
      div       <= DIV_SM;
      code      <= CMD_START;
      wdata     <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 1'b0;
      arb_lost  <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      cnt       <= cnt_n;
      div       <= div_n;
      code      <= code_n;
      wdata     <= wdata_n;
      scl_oe    <= scl_oe_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      arb_lost  <= arb_lost_n;
    end
  end

  // A slave holding SCL low during the released-high phase freezes the phase timer.
  assign stretch = ((state == BIT) || (state == STOP)) && (ph == 2'd1) && !scl_in;

  always_comb begin
    state_n     = state;
    ph_n        = ph;
    cnt_n       = cnt;
    div_n       = div;
    code_n      = code;
    wdata_n     = wdata;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    arb_lost_n  = 1'b0;
    arb         = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          code_n  = cmd_code;
          wdata_n = cmd_wdata;
          ph_n    = 2'd0;
          cnt_n   = 8'd0;
          case (freq_mode)
            2'b00: div_n = DIV_SM;
            2'b01: div_n = DIV_FM;
            2'b10: div_n = DIV_FMP;
            2'b11: div_n = DIV_HS;
          endcase
          case (cmd_code)
            CMD_START: state_n = START;
            CMD_STOP:  state_n = STOP;
            default:   state_n = BIT;
          endcase
        end
      end
      default: begin
        if (!stretch) begin
          if (cnt == div) begin
            cnt_n = 8'd0;
            if ((state == BIT) && (ph == 2'd2)) begin
              if ((code == CMD_WRITE) && wdata && !sda_in) begin
                arb         = 1'b1;
                state_n     = IDLE;
                ph_n        = 2'd0;
                arb_lost_n  = 1'b1;
                rsp_rdata_n = 1'b0;
              end else begin
                rsp_rdata_n = sda_in;
              end
            end
            if (!arb) begin
              if (ph == 2'd3) begin
                state_n     = IDLE;
                ph_n        = 2'd0;
                rsp_valid_n = 1'b1;
              end else begin
                ph_n = ph + 2'd1;
              end
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
    endcase

    // Line enables follow the phase being entered; idle keeps the last drive.
    scl_oe_n = scl_oe;
    sda_oe_n = sda_oe;
    if (arb) begin
      scl_oe_n = 1'b0;
      sda_oe_n = 1'b0;
    end else begin
      case (state_n)
        START: begin
          scl_oe_n = (ph_n == 2'd3);
          sda_oe_n = ph_n[1];
        end
        STOP: begin
          scl_oe_n = (ph_n == 2'd0);
          sda_oe_n = !ph_n[1];
        end
        BIT: begin
          scl_oe_n = (ph_n == 2'd0) || (ph_n == 2'd3);
          sda_oe_n = (code_n == CMD_WRITE) ? !wdata_n : 1'b0;
        end
        default: begin
          scl_oe_n = scl_oe_n;
          sda_oe_n = sda_oe_n;
        end
      endcase
    end

    busy_n      = (state_n != IDLE);
    cmd_ready_n = (state_n == IDLE);
  end

endmodule
